// File: rtl/sqrt_fsm.sv
// sqrt_fsm -- multi-cycle IEEE-754 single-precision square root.
//
// Takes one operand per request, computes the mantissa root with a restoring
// digit-by-digit loop (one root bit per clock) and reports a truncated result.
// Fixed latency: accept at E0, res/err written at E26, r_o pulses at E27.
// Denormal inputs are flushed to zero; negative nonzero, inf and NaN inputs
// give the canonical quiet NaN with err=1.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   x    - operand, sampled only on the accepting edge
//   r_i  - request, honoured only in IDLE
//   res  - registered result, held until the next PACK
//   err  - registered invalid-operand flag, updated with res
//   r_o  - one-cycle result-ready pulse per accepted request

module sqrt_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic        r_i,
    output logic [31:0] res,
    output logic        err,
    output logic        r_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] ITER   = 3'd2;
    localparam logic [2:0] PACK   = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INV  = 2'd2;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [2:0]  state;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic [47:0] rad;    // radicand, shifted left 2 bits per iteration
    logic [7:0]  re;     // biased result exponent
    logic [1:0]  cls;
    logic [23:0] root;
    logic [25:0] rem;    // partial remainder never exceeds 2*root
    logic [4:0]  cnt;

    // One restoring step: bring down the next two radicand bits and try to
    // subtract 4*root+1.
    logic [27:0] trial_in;
    logic [27:0] trial_sub;
    logic [27:0] trial;
    logic        ge;

    always_comb begin
        trial_in  = {rem, rad[47:46]};
        trial_sub = {2'b00, root, 2'b01};
        trial     = trial_in - trial_sub;
        ge        = (trial_in >= trial_sub);
    end

    // Result exponent: (e+127)>>1 for odd e, (e+126)>>1 for even e. With
    // e = 2k+b this is k+64 (odd) or k+63 (even), at most 191, so 8 bits
    // are enough and no wider intermediate is needed.
    logic [7:0] re_calc;
    always_comb begin
        re_calc = {1'b0, e[7:1]} + (e[0] ? 8'd64 : 8'd63);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= 1'b0;
            e     <= 8'd0;
            f     <= 23'd0;
            rad   <= 48'd0;
            re    <= 8'd0;
            cls   <= CLS_NORM;
            root  <= 24'd0;
            rem   <= 26'd0;
            cnt   <= 5'd0;
            res   <= 32'd0;
            err   <= 1'b0;
            r_o   <= 1'b0;
        end else begin
            r_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_i) begin
                        s     <= x[31];
                        e     <= x[30:23];
                        f     <= x[22:0];
                        root  <= 24'd0;
                        rem   <= 26'd0;
                        cnt   <= 5'd0;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    // Odd e leaves an even unbiased exponent, so the mantissa
                    // goes in unscaled; even e folds one factor of 2 into it.
                    if (e[0]) rad <= {1'b0, 1'b1, f, 23'd0};
                    else      rad <= {1'b1, f, 24'd0};
                    re <= re_calc;
                    if (e == 8'd0)              cls <= CLS_ZERO;
                    else if (s || e == 8'hFF)   cls <= CLS_INV;
                    else                        cls <= CLS_NORM;
                    cnt   <= 5'd23;
                    state <= ITER;
                end
                ITER: begin
                    rem   <= ge ? trial[25:0] : trial_in[25:0];
                    root  <= {root[22:0], ge};
                    rad   <= {rad[45:0], 2'b00};
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= PACK;
                end
                PACK: begin
                    case (cls)
                        CLS_ZERO: begin res <= {s, 31'd0};         err <= 1'b0; end
                        CLS_INV:  begin res <= QNAN;               err <= 1'b1; end
                        default:  begin res <= {1'b0, re, root[22:0]}; err <= 1'b0; end
                    endcase
                    state <= DONE;
                end
                DONE: begin
                    r_o   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_fsm.sv
// Self-checking bench for sqrt_fsm: directed roots, special operands,
// busy/back-to-back behaviour, reset abort, and random operands checked
// against an arithmetic reference model.

module tb_sqrt_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic        r_i;
    logic [31:0] res;
    logic        err;
    logic        r_o;

    int tests = 0;
    int fails = 0;

    sqrt_fsm dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .r_i (r_i),
        .res (res),
        .err (err),
        .r_o (r_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: sqrt of (1.f * 2^u) with truncation. Write u = 2q + p with
    // p in {0,1}; the root is sqrt(1.f * 2^p) * 2^q. Scale so the root
    // lands in [2^23, 2^24) and take the integer floor square root.
    function automatic logic [32:0] model(input logic [31:0] xv);
        logic        sg;
        int          ex;
        int          u;
        int          q;
        longint unsigned m;
        longint unsigned big;
        longint unsigned r;
        longint unsigned t;
        sg = xv[31];
        ex = int'(xv[30:23]);
        if (ex == 0) return {1'b0, sg, 31'd0};
        if (ex == 255 || sg) return {1'b1, 32'h7FC0_0000};
        m   = {40'd0, 1'b1, xv[22:0]};
        u   = ex - 127;
        q   = u >>> 1;
        big = m << (23 + (u - 2 * q));
        r   = 0;
        for (int b = 23; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= big) r = t;
        end
        return {1'b0, 1'b0, 8'(q + 127), r[22:0]};
    endfunction

    task automatic do_op(input logic [31:0] xv, input logic [31:0] er, input logic ee,
                         input string tag);
        int n;
        @(negedge clk);
        x   = xv;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!r_o && n < 60);
        check({tag, " latency"}, n, 27);
        check({tag, " res"}, res, er);
        check({tag, " err"}, {31'd0, err}, {31'd0, ee});
        @(posedge clk);
        #1;
        check({tag, " r_o width"}, {31'd0, r_o}, 32'd0);
    endtask

    initial begin : main
        logic [32:0] m;
        logic [31:0] xv;
        int n;
        int pulses;
        int pos[3];

        rst = 1'b1;
        r_i = 1'b0;
        x   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset res", res, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset r_o", {31'd0, r_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values
        do_op(32'h4080_0000, 32'h4000_0000, 1'b0, "sqrt4");
        do_op(32'h4110_0000, 32'h4040_0000, 1'b0, "sqrt9");
        do_op(32'h3E80_0000, 32'h3F00_0000, 1'b0, "sqrt0.25");
        do_op(32'h4000_0000, 32'h3FB5_04F3, 1'b0, "sqrt2");
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "sqrt1");
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, "+zero");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, "-zero");
        do_op(32'h0000_0001, 32'h0000_0000, 1'b0, "denorm");
        do_op(32'hBF80_0000, 32'h7FC0_0000, 1'b1, "neg1");
        do_op(32'h7F80_0000, 32'h7FC0_0000, 1'b1, "+inf");
        do_op(32'h7FC0_0001, 32'h7FC0_0000, 1'b1, "nan");

        // Random operands, biased toward positive normals
        for (int i = 0; i < 24; i++) begin
            xv = $urandom;
            if (i % 3 == 0) xv[31] = 1'b0;
            if (i % 4 == 1) begin
                xv[31]    = 1'b0;
                xv[30:23] = 8'($urandom_range(1, 254));
            end
            m = model(xv);
            do_op(xv, m[31:0], m[32], $sformatf("rand%0d x=%h", i, xv));
        end

        // Request during ITER is ignored, as is the x change
        @(negedge clk);
        x   = 32'h4080_0000;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        x   = 32'h4110_0000;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        n = 10;
        while (!r_o && n < 60) begin @(posedge clk); #1; n++; end
        check("busy latency", n, 27);
        check("busy res", res, 32'h4000_0000);
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (r_o) pulses++; end
        check("busy single r_o", pulses, 0);

        // r_i held high: one result per 28 cycles
        @(negedge clk);
        x   = 32'h4110_0000;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        pulses = 0;
        pos = '{0, 0, 0};
        while (pulses < 3 && n < 120) begin
            @(posedge clk);
            #1;
            n++;
            if (r_o) begin
                pos[pulses] = n;
                pulses++;
                if (pulses == 3) r_i = 1'b0;
            end
        end
        r_i = 1'b0;
        check("hold pulses", pulses, 3);
        check("hold pulse0", pos[0], 27);
        check("hold pulse1", pos[1], 55);
        check("hold pulse2", pos[2], 83);
        check("hold res", res, 32'h4040_0000);
        pulses = 0;
        repeat (35) begin @(posedge clk); #1; if (r_o) pulses++; end
        check("hold drained", pulses, 0);

        // Reset at E10 aborts the operation
        do_op(32'hBF80_0000, 32'h7FC0_0000, 1'b1, "pre-reset");
        @(negedge clk);
        x   = 32'h4080_0000;
        r_i = 1'b1;
        @(posedge clk);
        #1;
        r_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort res", res, 32'd0);
        check("abort err", {31'd0, err}, 32'd0);
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (r_o) pulses++; end
        check("abort no r_o", pulses, 0);
        check("abort res held", res, 32'd0);
        do_op(32'h3E80_0000, 32'h3F00_0000, 1'b0, "post-reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
